// File: rtl/cnn_accel_pkg.sv
// cnn_accel_pkg: shared state encoding, lane geometry and default bus bases
// for the cnn_accel_loader sequencer and its word packer.
package cnn_accel_pkg;
    typedef enum logic [3:0] {
        IDLE, DCOLS, DROWS, DLOAD, DDRAIN, FCOLS, FROWS, FLOAD, FDRAIN, START, RUN
    } state_t;
    localparam int NUM_WORDS = 2;
    localparam int WE_WIDTH = 4;
    localparam int DEF_MAX_SIZE = 4096;
    localparam int DIM_WIDTH = $clog2(DEF_MAX_SIZE) + 1;
    localparam int DEF_DATA_BASE = 0;
    localparam int DEF_FILT_BASE = 16384;
endpackage

// File: rtl/cnn_word_packer.sv
// cnn_word_packer: pairs stream words into bus writes, lane0 in the low half;
// a lone lane0 word on last is flushed with only its own byte enables.
module cnn_word_packer
    import cnn_accel_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rstN,
    input  logic                              init,
    input  logic [ADDR_WIDTH-1:0]             base,
    input  logic                              beat,
    input  logic                              last,
    input  logic [WORD_WIDTH-1:0]             word,
    output logic [ADDR_WIDTH-1:0]             addr,
    output logic [NUM_WORDS*WE_WIDTH-1:0]     wrEn,
    output logic [NUM_WORDS*WORD_WIDTH-1:0]   wrData
);
    localparam int BYTES = NUM_WORDS * WORD_WIDTH / 8;
    logic lane;
    logic flush;
    logic [WORD_WIDTH-1:0] held;
    logic [ADDR_WIDTH-1:0] nextAddr;

    assign flush = beat && (lane || last);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lane <= 1'b0;
            held <= '0;
            nextAddr <= '0;
            addr <= '0;
            wrEn <= '0;
            wrData <= '0;
        end else begin
            wrEn <= flush ? (lane ? '1 : {{WE_WIDTH{1'b0}}, {WE_WIDTH{1'b1}}}) : '0;
            if (init) begin
                lane <= 1'b0;
                nextAddr <= base;
            end else if (beat) begin
                lane <= !last && !lane;
                if (!lane) held <= word;
                if (flush) begin
                    addr <= nextAddr;
                    nextAddr <= nextAddr + ADDR_WIDTH'(BYTES);
                    wrData <= lane ? {word, held} : {{WORD_WIDTH{1'b0}}, word};
                end
            end
        end
    end
endmodule

// File: rtl/cnn_accel_loader.sv
// cnn_accel_loader: loads image and kernel streams into the accelerator, then starts it.
// Define CNN_LOADER_PERF_EN to count compute cycles on cyclesOut.
module cnn_accel_loader
    import cnn_accel_pkg::*;
#(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_SIZE = DEF_MAX_SIZE,
    parameter logic [BUS_ADDR_WIDTH-1:0] DATA_BASE = BUS_ADDR_WIDTH'(DEF_DATA_BASE),
    parameter logic [BUS_ADDR_WIDTH-1:0] FILT_BASE = BUS_ADDR_WIDTH'(DEF_FILT_BASE)
) (
    input  logic                          clkIn,
    input  logic                          rstIn,
    input  logic [DATA_WIDTH-1:0]         dataIn,
    input  logic                          dataValidIn,
    input  logic                          dataLastIn,
    output logic                          dataReadyOut,
    input  logic [DATA_WIDTH-1:0]         filtIn,
    input  logic                          filtValidIn,
    input  logic                          filtLastIn,
    output logic                          filtReadyOut,
    output logic [DIM_WIDTH-1:0]          dataRowsOut,
    output logic [DIM_WIDTH-1:0]          dataColsOut,
    output logic [DIM_WIDTH-1:0]          filtRowsOut,
    output logic [DIM_WIDTH-1:0]          filtColsOut,
    output logic [BUS_ADDR_WIDTH-1:0]     addrOut,
    output logic [NUM_WORDS*WE_WIDTH-1:0] wrEnOut,
    output logic [BUS_DATA_WIDTH-1:0]     wrDataOut,
    output logic                          startOut,
    input  logic                          doneIn,
    output logic                          busyOut,
    output logic                          doneOut,
    output logic                          errorOut,
    output logic [31:0]                   cyclesOut
);
    localparam int PW = 2 * DIM_WIDTH;
    state_t state;
    logic dataBeat, filtBeat, inFilt, curBeat, curLast, hdrBad, loadErr, pkInit, pkBeat;
    logic [DATA_WIDTH-1:0] curWord;
    logic [DIM_WIDTH-1:0] curCols;
    logic [PW-1:0] prod, expected, wordCnt, cnt1;

    always_comb begin
        dataBeat = dataValidIn && dataReadyOut;
        filtBeat = filtValidIn && filtReadyOut;
        inFilt = state inside {FCOLS, FROWS, FLOAD, FDRAIN};
        curBeat = inFilt ? filtBeat : dataBeat;
        curLast = inFilt ? filtLastIn : dataLastIn;
        curWord = inFilt ? filtIn : dataIn;
        curCols = inFilt ? filtColsOut : dataColsOut;
        prod = {{DIM_WIDTH{1'b0}}, curWord[DIM_WIDTH-1:0]} * {{DIM_WIDTH{1'b0}}, curCols};
        // a header ending the stream leaves no payload to match the length
        hdrBad = prod == '0 || prod > PW'(MAX_SIZE) || curLast;
        cnt1 = wordCnt + PW'(1);
        loadErr = curLast != (cnt1 == expected);
        pkInit = (state == DROWS || state == FROWS) && curBeat && !hdrBad;
        pkBeat = (state == DLOAD || state == FLOAD) && curBeat && !loadErr;
    end

    cnn_word_packer #(.ADDR_WIDTH(BUS_ADDR_WIDTH), .WORD_WIDTH(DATA_WIDTH)) packer (
        .clk(clkIn), .rstN(rstIn), .init(pkInit), .base(inFilt ? FILT_BASE : DATA_BASE),
        .beat(pkBeat), .last(curLast), .word(curWord),
        .addr(addrOut), .wrEn(wrEnOut), .wrData(wrDataOut)
    );

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state <= IDLE;
            {dataReadyOut, filtReadyOut, startOut, busyOut, doneOut, errorOut} <= '0;
            {dataRowsOut, dataColsOut, filtRowsOut, filtColsOut} <= '0;
            expected <= '0;
            wordCnt <= '0;
        end else begin
            startOut <= 1'b0;
            doneOut <= 1'b0;
            case (state)
                IDLE: if (dataValidIn) begin
                    state <= DCOLS;
                    dataReadyOut <= 1'b1;
                    busyOut <= 1'b1;
                    errorOut <= 1'b0;
                end
                DCOLS, FCOLS: if (curBeat) begin
                    if (inFilt) filtColsOut <= curWord[DIM_WIDTH-1:0];
                    else dataColsOut <= curWord[DIM_WIDTH-1:0];
                    state <= inFilt ? FROWS : DROWS;
                end
                DROWS, FROWS: if (curBeat) begin
                    if (inFilt) filtRowsOut <= curWord[DIM_WIDTH-1:0];
                    else dataRowsOut <= curWord[DIM_WIDTH-1:0];
                    expected <= prod;
                    wordCnt <= '0;
                    if (!hdrBad) state <= inFilt ? FLOAD : DLOAD;
                    else begin
                        errorOut <= 1'b1;
                        if (curLast) begin
                            state <= IDLE;
                            {dataReadyOut, filtReadyOut, busyOut, doneOut} <= 4'b0001;
                        end else state <= inFilt ? FDRAIN : DDRAIN;
                    end
                end
                DLOAD, FLOAD: if (curBeat) begin
                    wordCnt <= cnt1;
                    if (loadErr) begin
                        errorOut <= 1'b1;
                        if (curLast) begin
                            state <= IDLE;
                            {dataReadyOut, filtReadyOut, busyOut, doneOut} <= 4'b0001;
                        end else state <= inFilt ? FDRAIN : DDRAIN;
                    end else if (curLast) begin
                        state <= inFilt ? START : FCOLS;
                        dataReadyOut <= 1'b0;
                        filtReadyOut <= !inFilt;
                    end
                end
                DDRAIN, FDRAIN: if (curBeat && curLast) begin
                    state <= IDLE;
                    {dataReadyOut, filtReadyOut, busyOut, doneOut} <= 4'b0001;
                end
                START: begin
                    startOut <= 1'b1;
                    state <= RUN;
                end
                RUN: if (doneIn) begin
                    state <= IDLE;
                    busyOut <= 1'b0;
                    doneOut <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CNN_LOADER_PERF_EN
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) cyclesOut <= '0;
        else if (state == START) cyclesOut <= '0;
        else if (state == RUN && cyclesOut != '1) cyclesOut <= cyclesOut + 32'(1);
    end
`else
    assign cyclesOut = '0;
`endif
endmodule
